// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the elastic pipeline stage registers:
//   - NOP          : RISC-V canonical no-op (addi x0, x0, 0)
//   - stage_state_t: occupancy state of one pipeline stage
//   - BUBBLE_*     : default bubble payloads for the core's stage registers,
//                    laid out as {upper word, instruction} with a NOP in the
//                    instruction slot.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam logic [63:0] BUBBLE_IF_ID  = {32'h0, NOP};
  localparam logic [63:0] BUBBLE_ID_EX  = {32'h0, NOP};
  localparam logic [63:0] BUBBLE_EX_MEM = {32'h0, NOP};
  localparam logic [63:0] BUBBLE_MEM_WB = {32'h0, NOP};

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot
//   One storage entry of a pipeline stage: valid flag, payload and control.
//   Ports:
//     clk, rst           - clock, asynchronous active-high reset
//     clear              - return the slot to a bubble (has priority over load)
//     load               - capture load_data/load_ctrl and mark valid
//     load_data/ctrl     - value to capture
//     valid/data/ctrl    - registered slot contents; a bubble holds
//                          BUBBLE_DATA and zero control
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 8,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = DATA_W'(NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Bubble contents are stored rather than gated at the output so the
  // downstream stage always sees a clean registered NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= BUBBLE_DATA;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= BUBBLE_DATA;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic valid/ready pipeline register carrying a payload and a control
//   sideband between two core stages. Flush and reset leave a bubble.
//   Optional feature macro: PIPE_STAGE_SKID_EN
//     defined   - second (skid) entry, registered in_ready, full throughput
//     undefined - single entry, in_ready = !out_valid || out_ready
//   Ports:
//     clk, rst                     - clock, asynchronous active-high reset
//     flush                        - synchronous kill of held and incoming entries
//     in_valid/in_ready            - upstream handshake
//     in_data/in_ctrl              - upstream payload and control
//     out_valid/out_ready          - downstream handshake
//     out_data/out_ctrl            - presented payload and control (registered)
//     occupancy                    - number of held entries (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 8,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = DATA_W'(BUBBLE_IF_ID)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_t      state, state_next;
  logic              in_fire, out_fire;
  logic              main_load, main_clear;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // The main slot is the presented entry; its registers are the outputs.
  pipe_stage_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_src_data),
    .load_ctrl (main_src_ctrl),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load, skid_clear, skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  pipe_stage_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (skid_clear),
    .load      (skid_load),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  // in_ready is registered from the next state so that out_ready never
  // reaches in_ready combinationally; the skid entry absorbs the one entry
  // that may arrive while the stage fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_next != ST_TWO);
    end
  end

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
`else
  assign in_ready  = !out_valid || out_ready;
  assign occupancy = {1'b0, out_valid};
`endif

  // Stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and slot control. Flush wins over any transfer; in TWO the
  // skid entry is promoted into main when the presented entry leaves.
  always_comb begin
    state_next    = state;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
`endif
    if (flush) begin
      state_next = ST_EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load  = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_next = ST_EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_fire) begin
            skid_load  = 1'b1;
            state_next = ST_TWO;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_TWO: begin
          if (out_fire) begin
            main_load     = 1'b1;
            main_src_data = skid_data;
            main_src_ctrl = skid_ctrl;
            skid_clear    = 1'b1;
            state_next    = ST_ONE;
          end
        end
`endif
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers of the RISC-V core with one reusable block. It carries a data payload and a control sideband between two stages using a valid/ready handshake, so backpressure propagates instead of relying on global stall wires. An optional skid entry provides full throughput with a registered `in_ready`. Flush and reset turn the stage into a bubble: NOP payload, zeroed control.

## Interface
- `DATA_W`, default 64: payload width (e.g. {pc_plus_4, instruction}).
- `CTRL_W`, default 8: control sideband width (reg_write, mem_read, …).
- `BUBBLE_DATA`, default {32'h0, 32'h00000013}: payload driven while the stage holds no valid entry.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of all held and incoming entries.
- `in_valid`  in  1  upstream offers an entry.
- `in_ready`  out  1  stage can accept; a transfer occurs when `in_valid && in_ready`.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control.
- `out_valid`  out  1  stage presents an entry.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_data`  out  DATA_W  presented payload.
- `out_ctrl`  out  CTRL_W  presented control.
- `occupancy`  out  2  number of held entries: 0, 1, or 2 (2 only with skid).

## Operation
- Storage:
  - main register: valid, data, ctrl.
  - optional skid register with the same fields.
- States (with skid):
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY→ONE on input transfer.
  - ONE→ONE on simultaneous in/out transfer, or on neither.
  - ONE→TWO on input transfer without output transfer; the new entry goes to skid.
  - ONE→EMPTY on output transfer only.
  - TWO→ONE on output transfer; skid moves to main.
- In TWO, `in_ready` = 0, so no input transfer is possible.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
- Invalid output: whenever `out_valid` = 0, `out_data` = BUBBLE_DATA and `out_ctrl` = 0.
  - These values are registered, not gated combinationally.
- Flush:
  - Next state is EMPTY.
  - Any entry offered in the same cycle is discarded. Upstream treats it as consumed because `in_ready` is not affected by `flush`.
  - Flush has priority over all transfers.
- `out_ready` low with `out_valid` high: `out_data` and `out_ctrl` stay stable until the transfer.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = BUBBLE_DATA, `out_ctrl` = 0.
  - `occupancy` = 0, `in_ready` = 1.
- Latency: 1 cycle from input transfer to `out_valid`. No combinational path from `in_*` to `out_*`.
- Throughput: one entry per cycle while `out_ready` is held high.
- Reset mid-operation: all entries are dropped immediately. Outputs take reset values asynchronously.
- `flush` and `rst` asserted together: reset dominates; the result is identical.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid register is present.
  - `in_ready` is a register output equal to (occupancy < 2).
  - No combinational `out_ready`→`in_ready` path.
- `PIPE_STAGE_SKID_EN` undefined:
  - Main register only; occupancy ≤ 1.
  - `in_ready` = !out_valid || out_ready, combinational, single-entry pass-through behaviour.
- All other behaviour is identical in both configurations.

## Structure
- Package `pipe_pkg`:
  - NOP constant 32'h00000013.
  - Stage state typedef (EMPTY/ONE/TWO).
  - Default BUBBLE_DATA constants per core stage.
- One sub-module, `pipe_stage_slot`: a single valid/data/ctrl register with load and clear-to-bubble. Instantiated once for main and once for skid.

## Test plan
- Reset: assert `rst` mid-stream → `out_valid` = 0, `out_data` = 64'h00000000_00000013, `out_ctrl` = 0, `occupancy` = 0 within the same cycle.
- Streaming: `out_ready` = 1, ten entries 1..10 offered back-to-back → 1..10 appear in order, one per cycle, 1-cycle latency.
- Backpressure (skid enabled): `out_ready` = 0 while offering A, B, C → A, B accepted, `in_ready` drops with occupancy = 2, C held upstream. Raise `out_ready` → A, B, C delivered in order.
- Flush with full stage: occupancy = 2 and `flush` with `in_valid` = 1 → next cycle occupancy = 0, `out_valid` = 0, offered entry never appears.
- Simultaneous in/out in ONE: entry X held, Y offered, `out_ready` = 1 → X delivered, Y presented next cycle, occupancy stays 1.
- Skid disabled: with `out_valid` = 1, `out_ready` = 0 → `in_ready` = 0 in the same cycle. Toggle `out_ready` = 1 → `in_ready` = 1 combinationally.
